// File: rtl/regfile_writeback_queue_pkg.sv
// gpu_wb_pkg: shared types and constants for the register-file write-back queue.
//   Source indices, read-only register boundary, register-file input-mux codes,
//   the queued write entry type and a register one-hot helper.
package gpu_wb_pkg;
    localparam int DATA_BITS     = 16;
    localparam int REG_ADDR_BITS = 4;
    localparam int NUM_REGS      = 1 << REG_ADDR_BITS;
    localparam int NUM_SRC       = 4;
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_FMA = 2;
    localparam int SRC_ACT = 3;
    localparam logic [REG_ADDR_BITS-1:0] REG_RO_FIRST = 4'd13;
    typedef enum logic [2:0] {
        RF_SEL_ALU   = 3'b000,
        RF_SEL_MEM   = 3'b001,
        RF_SEL_CONST = 3'b010,
        RF_SEL_FMA   = 3'b011,
        RF_SEL_ACT   = 3'b100
    } rf_in_sel_e;
    typedef struct packed {
        logic [REG_ADDR_BITS-1:0] rd;
        logic [DATA_BITS-1:0]     data;
    } wb_entry_t;
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_BITS-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/regfile_writeback_queue_if.sv
// regfile_writeback_queue_if: result sources -> queue -> register-file write port.
//   src_valid/src_rd/src_data/src_ready : four result sources, index i packed at [i*W +: W]
//   wb_valid/wb_rd/wb_data/wb_ready     : one register-file write per cycle
//   busy                                : registers with a write in flight
//   err_ro_write                        : sticky flag, a write to a read-only register was dropped
//   master = the queue, slave = sources / register file.
interface regfile_writeback_queue_if;
    import gpu_wb_pkg::*;
    logic [NUM_SRC-1:0]               src_valid;
    logic [NUM_SRC*REG_ADDR_BITS-1:0] src_rd;
    logic [NUM_SRC*DATA_BITS-1:0]     src_data;
    logic [NUM_SRC-1:0]               src_ready;
    logic                             wb_ready;
    logic                             wb_valid;
    logic [REG_ADDR_BITS-1:0]         wb_rd;
    logic [DATA_BITS-1:0]             wb_data;
    logic [NUM_REGS-1:0]              busy;
    logic                             err_ro_write;
    modport master (
        input  src_valid, src_rd, src_data, wb_ready,
        output src_ready, wb_valid, wb_rd, wb_data, busy, err_ro_write
    );
    modport slave (
        output src_valid, src_rd, src_data, wb_ready,
        input  src_ready, wb_valid, wb_rd, wb_data, busy, err_ro_write
    );
endinterface

// File: rtl/regfile_writeback_queue_wb_fifo.sv
// wb_fifo: synchronous in-order FIFO of wb_entry_t, DEPTH a power of two >= 2.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO, clears storage)
//   push, din   : enqueue din (caller guarantees !full || pop)
//   pop         : dequeue head (caller guarantees !empty)
//   head        : oldest entry, register-driven
//   full, empty, count
//   occupied, entries : per-slot valid bit and contents, for the busy reduction
module wb_fifo
    import gpu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  wb_entry_t                   din,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DEPTH-1:0]            occupied,
    output wb_entry_t [DEPTH-1:0]       entries
);
    localparam int PTR_W = $clog2(DEPTH);
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_occ
        logic [PTR_W-1:0] off;
        assign off = PTR_W'(i) - rd_ptr_q;
        assign occupied[i] = {1'b0, off} < count_q;
    end
    assign entries = mem_q;
    assign head    = mem_q[rd_ptr_q];
    assign empty   = count_q == '0;
    assign full    = count_q == (PTR_W+1)'(DEPTH);
    assign count   = count_q;
    a_no_xflow: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop) && !(pop && empty));
endmodule

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: collects ALU/LSU/FMA/ACT results and serialises them
//   into one register-file write per cycle, exporting a per-register busy mask.
//   clk, reset : clock, synchronous active-high reset (discards queued writes)
//   wb         : regfile_writeback_queue_if.master (sources, write port, busy, err_ro_write)
//   DEPTH      : FIFO entries, power of two >= 2
//   Optional macro WB_BYPASS_EN: with an empty FIFO and wb_ready=1 the granted
//   write is presented combinationally in the accept cycle instead of being queued.
module regfile_writeback_queue
    import gpu_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                        clk,
    input logic                        reset,
    regfile_writeback_queue_if.master  wb
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic [1:0] sel;
    logic [NUM_SRC-1:0] grant;
    logic [REG_ADDR_BITS-1:0] g_rd;
    logic [DATA_BITS-1:0] g_data;
    logic space, accept, ro, byp, push, pop, full, empty;
    logic err_ro_q, err_ro_d;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] occupied;
    logic [NUM_REGS-1:0] busy;
    wb_entry_t head;
    wb_entry_t [DEPTH-1:0] entries;
    // Fixed priority LSU > FMA > ACT > ALU; ALU is the fallback index.
    always_comb begin
        sel = wb.src_valid[SRC_LSU] ? 2'(SRC_LSU) :
              wb.src_valid[SRC_FMA] ? 2'(SRC_FMA) :
              wb.src_valid[SRC_ACT] ? 2'(SRC_ACT) : 2'(SRC_ALU);
        grant  = |wb.src_valid ? NUM_SRC'(1) << sel : '0;
        g_rd   = wb.src_rd[sel*REG_ADDR_BITS +: REG_ADDR_BITS];
        g_data = wb.src_data[sel*DATA_BITS +: DATA_BITS];
        pop    = !empty && wb.wb_ready;
        // A pop on a full FIFO frees the slot this cycle's push uses.
        space  = !full || pop;
        accept = |grant && space;
        ro     = g_rd >= REG_RO_FIRST;
`ifdef WB_BYPASS_EN
        byp    = accept && !ro && empty && wb.wb_ready;
`else
        byp    = 1'b0;
`endif
        push     = accept && !ro && !byp;
        err_ro_d = err_ro_q || (accept && ro);
    end
    always_ff @(posedge clk) begin
        if (reset) err_ro_q <= 1'b0;
        else       err_ro_q <= err_ro_d;
    end
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .din      ('{rd: g_rd, data: g_data}),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .occupied (occupied),
        .entries  (entries)
    );
    always_comb begin
        busy = byp ? rd_onehot(g_rd) : '0;
        for (int i = 0; i < DEPTH; i++) busy |= occupied[i] ? rd_onehot(entries[i].rd) : '0;
    end
    assign wb.src_ready    = space ? grant : '0;
    assign wb.wb_valid     = !empty || byp;
    assign wb.wb_rd        = byp ? g_rd : head.rd;
    assign wb.wb_data      = byp ? g_data : head.data;
    assign wb.busy         = busy;
    assign wb.err_ro_write = err_ro_q;
    a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: directed checks of arbitration, ordering, full, read-only guard and reset.
module tb_regfile_writeback_queue;
    import gpu_wb_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests_run = 0;
    int tests_failed = 0;
    regfile_writeback_queue_if bus();
    regfile_writeback_queue #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .wb(bus.master));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [3:0] rd, input logic [15:0] data);
        bus.src_valid[i] = 1'b1;
        bus.src_rd[i*4 +: 4] = rd;
        bus.src_data[i*16 +: 16] = data;
    endtask

    task automatic idle();
        bus.src_valid = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); bus.src_rd = '0; bus.src_data = '0; bus.wb_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        tests_run++; if (bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
        tests_run++; if (bus.wb_rd !== 4'd0 || bus.wb_data !== 16'h0) begin tests_failed++; $display("FAIL reset_wb_bus got %h/%h want 0/0", bus.wb_rd, bus.wb_data); end
        tests_run++; if (bus.busy !== 16'h0) begin tests_failed++; $display("FAIL reset_busy got %h want 0000", bus.busy); end
        tests_run++; if (bus.err_ro_write !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", bus.err_ro_write); end
    endtask

    task automatic test_single();
        bus.wb_ready = 1'b1;
        set_src(SRC_ALU, 4'd3, 16'h4000);
        #1;
        tests_run++; if (bus.src_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_ready got %b want 0001", bus.src_ready); end
`ifdef WB_BYPASS_EN
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'd3 || bus.wb_data !== 16'h4000) begin tests_failed++; $display("FAIL single_bypass got %b/%h/%h want 1/3/4000", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        tests_run++; if (bus.busy !== 16'h0008) begin tests_failed++; $display("FAIL single_bypass_busy got %h want 0008", bus.busy); end
        step(); idle(); #1;
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.busy !== 16'h0) begin tests_failed++; $display("FAIL single_after_bypass got %b/%h want 0/0000", bus.wb_valid, bus.busy); end
`else
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.busy !== 16'h0) begin tests_failed++; $display("FAIL single_accept_cycle got %b/%h want 0/0000", bus.wb_valid, bus.busy); end
        step(); idle(); #1;
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'd3 || bus.wb_data !== 16'h4000) begin tests_failed++; $display("FAIL single_out got %b/%h/%h want 1/3/4000", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        tests_run++; if (bus.busy !== 16'h0008) begin tests_failed++; $display("FAIL single_busy got %h want 0008", bus.busy); end
        step();
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.busy !== 16'h0) begin tests_failed++; $display("FAIL single_popped got %b/%h want 0/0000", bus.wb_valid, bus.busy); end
`endif
    endtask

    task automatic test_contention();
        bus.wb_ready = 1'b0;
        set_src(SRC_LSU, 4'd1, 16'h1111);
        set_src(SRC_FMA, 4'd2, 16'h2222);
        #1;
        tests_run++; if (bus.src_ready !== 4'b0010) begin tests_failed++; $display("FAIL cont_lsu_first got %b want 0010", bus.src_ready); end
        step(); bus.src_valid[SRC_LSU] = 1'b0; #1;
        tests_run++; if (bus.src_ready !== 4'b0100) begin tests_failed++; $display("FAIL cont_fma_next got %b want 0100", bus.src_ready); end
        tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'd1) begin tests_failed++; $display("FAIL cont_head_lsu got %b/%h want 1/1", bus.wb_valid, bus.wb_rd); end
        step(); idle(); #1;
        tests_run++; if (bus.busy !== 16'h0006 || bus.wb_data !== 16'h1111) begin tests_failed++; $display("FAIL cont_busy got %h/%h want 0006/1111", bus.busy, bus.wb_data); end
        bus.wb_ready = 1'b1;
        step();
        tests_run++; if (bus.wb_rd !== 4'd2 || bus.wb_data !== 16'h2222) begin tests_failed++; $display("FAIL cont_second got %h/%h want 2/2222", bus.wb_rd, bus.wb_data); end
        step();
        tests_run++; if (bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL cont_drained got %b want 0", bus.wb_valid); end
    endtask

    task automatic test_full();
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_src(SRC_ALU, 4'(6 + k), 16'(6 + k));
            step();
        end
        idle();
        set_src(SRC_ACT, 4'd10, 16'h000A);
        #1;
        tests_run++; if (bus.src_ready !== 4'b0000) begin tests_failed++; $display("FAIL full_ready got %b want 0000", bus.src_ready); end
        tests_run++; if (bus.busy !== 16'h03C0) begin tests_failed++; $display("FAIL full_busy got %h want 03c0", bus.busy); end
        bus.wb_ready = 1'b1;
        #1;
        tests_run++; if (bus.src_ready !== 4'b1000 || bus.wb_rd !== 4'd6) begin tests_failed++; $display("FAIL full_pop_push got %b/%h want 1000/6", bus.src_ready, bus.wb_rd); end
        step(); idle(); bus.wb_ready = 1'b0;
        set_src(SRC_ALU, 4'd11, 16'h000B);
        #1;
        tests_run++; if (bus.src_ready !== 4'b0000 || bus.busy !== 16'h0780) begin tests_failed++; $display("FAIL full_still_4 got %b/%h want 0000/0780", bus.src_ready, bus.busy); end
        idle();
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'(7 + k) || bus.wb_data !== 16'(7 + k)) begin tests_failed++; $display("FAIL full_drain%0d got %b/%h/%h want 1/%h/%h", k, bus.wb_valid, bus.wb_rd, bus.wb_data, 7 + k, 7 + k); end
            step();
        end
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.busy !== 16'h0) begin tests_failed++; $display("FAIL full_empty got %b/%h want 0/0000", bus.wb_valid, bus.busy); end
    endtask

    task automatic test_same_rd();
        bus.wb_ready = 1'b0;
        set_src(SRC_ALU, 4'd5, 16'h0001);
        step(); idle();
        set_src(SRC_ACT, 4'd5, 16'h7FFF);
        step(); idle(); #1;
        tests_run++; if (bus.busy !== 16'h0020 || bus.wb_data !== 16'h0001) begin tests_failed++; $display("FAIL same_first got %h/%h want 0020/0001", bus.busy, bus.wb_data); end
        bus.wb_ready = 1'b1;
        step();
        tests_run++; if (bus.busy !== 16'h0020 || bus.wb_data !== 16'h7FFF) begin tests_failed++; $display("FAIL same_second got %h/%h want 0020/7fff", bus.busy, bus.wb_data); end
        step();
        tests_run++; if (bus.busy !== 16'h0 || bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL same_done got %h/%b want 0000/0", bus.busy, bus.wb_valid); end
    endtask

    task automatic test_read_only();
        bus.wb_ready = 1'b1;
        set_src(SRC_LSU, 4'd14, 16'h1234);
        #1;
        tests_run++; if (bus.src_ready !== 4'b0010 || bus.wb_valid !== 1'b0) begin tests_failed++; $display("FAIL ro_accept got %b/%b want 0010/0", bus.src_ready, bus.wb_valid); end
        step(); idle(); #1;
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.busy !== 16'h0 || bus.err_ro_write !== 1'b1) begin tests_failed++; $display("FAIL ro_dropped got %b/%h/%b want 0/0000/1", bus.wb_valid, bus.busy, bus.err_ro_write); end
        step(); step();
        tests_run++; if (bus.err_ro_write !== 1'b1) begin tests_failed++; $display("FAIL ro_sticky got %b want 1", bus.err_ro_write); end
    endtask

    task automatic test_reset_mid();
        bus.wb_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            set_src(SRC_ALU, 4'(k), 16'(k));
            step();
        end
        idle(); #1;
        tests_run++; if (bus.busy !== 16'h000E) begin tests_failed++; $display("FAIL mid_queued got %h want 000e", bus.busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests_run++; if (bus.wb_valid !== 1'b0 || bus.busy !== 16'h0 || bus.err_ro_write !== 1'b0) begin tests_failed++; $display("FAIL mid_reset got %b/%h/%b want 0/0000/0", bus.wb_valid, bus.busy, bus.err_ro_write); end
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_same_rd();
        test_read_only();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
